regression_evaluator: RTL

- Inference/evaluation end of the regression datapath: the consumer of the trained `w1`, `w2`, `b` that the training top produces once `ready` rises.
- Latches the trained weights on `start`. Streams test samples `(x1, x2, t)` through a 2-stage multiply-accumulate pipeline. Emits a per-sample prediction `sign(w1*x1 + w2*x2 + b)`.
- Counts samples and mispredictions, and raises `done` when the stream ends.
- Sits beside the trainer and shares its 14-bit signed weight format.

---
 rtl/regression_evaluator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/regression_evaluator.sv
// Regression evaluator: latches trained weights on start, streams test
// samples through a two-stage multiply-accumulate pipeline, emits the
// per-sample sign prediction and counts samples and mispredictions.
module regression_evaluator #(
    parameter int DW = 14,
    parameter int CW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] w1,
    input  logic signed [DW-1:0] w2,
    input  logic signed [DW-1:0] b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_x1,
    input  logic signed [DW-1:0] in_x2,
    input  logic                 in_t,
    input  logic                 in_last,
    output logic                 out_valid,
    output logic                 out_pred,
    output logic                 out_err,
    output logic [CW-1:0]        sample_count,
    output logic [CW-1:0]        err_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t r_state;
    state_t w_state_next;

    logic signed [DW-1:0]     r_w1;
    logic signed [DW-1:0]     r_w2;
    logic signed [DW-1:0]     r_b;
    logic signed [2*DW-1:0]   r_p1;
    logic signed [2*DW-1:0]   r_p2;
    logic                     r_t1;
    logic                     r_v1;
    logic                     r_ov;
    logic                     r_pred;
    logic                     r_err;
    logic [CW-1:0]            r_sample_count;
    logic [CW-1:0]            r_err_count;

    logic                     w_accept;
    logic                     w_load;
    logic signed [2*DW-1:0]   w_w1_ext;
    logic signed [2*DW-1:0]   w_w2_ext;
    logic signed [2*DW-1:0]   w_x1_ext;
    logic signed [2*DW-1:0]   w_x2_ext;
    logic signed [2*DW-1:0]   w_p1;
    logic signed [2*DW-1:0]   w_p2;
    logic signed [2*DW+1:0]   w_sum;
    logic                     w_pred;

    // Samples are only taken in RUN; a start is only honoured from IDLE or DONE,
    // so a stray start mid-run can neither reload weights nor clear counters.
    assign w_accept = in_valid && (r_state == S_RUN);
    assign w_load   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Operands are widened to the full product width so the multiply is
    // evaluated at 2*DW bits without relying on context sizing.
    assign w_w1_ext = {{DW{r_w1[DW-1]}}, r_w1};
    assign w_w2_ext = {{DW{r_w2[DW-1]}}, r_w2};
    assign w_x1_ext = {{DW{in_x1[DW-1]}}, in_x1};
    assign w_x2_ext = {{DW{in_x2[DW-1]}}, in_x2};
    assign w_p1     = w_w1_ext * w_x1_ext;
    assign w_p2     = w_w2_ext * w_x2_ext;

    // Two guard bits make the three-term sum exact; s == 0 predicts +1.
    assign w_sum  = {{2{r_p1[2*DW-1]}}, r_p1}
                  + {{2{r_p2[2*DW-1]}}, r_p2}
                  + {{(DW+2){r_b[DW-1]}}, r_b};
    assign w_pred = ~w_sum[2*DW+1];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Next-state and state-decoded outputs.
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && in_last) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Stage 2 empties on the same edge stage 1 is seen empty, so
                // DONE lines up with the final sample being counted.
                if (!r_v1) w_state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Weight latch: captured once per run, isolated from later input changes.
    // NOTE: the weight and pipeline data registers are reset too, so a run
    // aborted by reset leaves nothing stale that could leak into outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w1 <= '0;
            r_w2 <= '0;
            r_b  <= '0;
        end else if (w_load) begin
            r_w1 <= w1;
            r_w2 <= w2;
            r_b  <= b;
        end
    end

    // Stage 1: products and target registered on the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_t1 <= 1'b0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_p1 <= w_p1;
                r_p2 <= w_p2;
                r_t1 <= in_t;
            end
        end
    end

    // Stage 2: sign decision and error flag; both hold while no sample arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ov   <= 1'b0;
            r_pred <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ov <= r_v1;
            if (r_v1) begin
                r_pred <= w_pred;
                r_err  <= w_pred ^ r_t1;
            end
        end
    end

    // Saturating run counters, cleared when a new run is launched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
        end else if (w_load) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
        end else if (r_ov) begin
            if (r_sample_count != CNT_MAX) r_sample_count <= r_sample_count + CW'(1);
            if (r_err && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + CW'(1);
        end
    end

    assign out_valid    = r_ov;
    assign out_pred     = r_pred;
    assign out_err      = r_err;
    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;

endmodule
